vid_frame_sched: RTL and testbench
==================================

Name: vid_frame_sched

Overview:
- Synthesizable parallel-video frame scheduler that sequences a pixel datapath into de/hs/vs timing.
- Uses the same polarity convention as the team's sim monitor: vs high for the whole frame, hs high during horizontal blank, de high on active pixels.
- Pulls pixels from an upstream ready/valid source, emits a programmable number of frames, and reports frame completion and underflow.
- Sits between a line buffer or filter output and video sinks or monitors.

Parameters:
- DATA_WIDTH, 8, pixel width.
- CNT_WIDTH, 12, width of all geometry and frame counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_pix_count  in  CNT_WIDTH  active pixels per line.
- cfg_line_count  in  CNT_WIDTH  active lines per frame.
- cfg_hblank  in  CNT_WIDTH  hblank cycles per line.
- cfg_vblank  in  CNT_WIDTH  vblank cycles before each frame.
- cfg_frames  in  CNT_WIDTH  frames to emit; 0 = continuous.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle stop request; honoured at frame end.
- s_di  in  DATA_WIDTH  upstream pixel.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  pixel accepted this cycle.
- di_o  out  DATA_WIDTH  video data.
- de_o  out  1  data enable.
- hs_o  out  1  horizontal blank, active high.
- vs_o  out  1  frame active, active high.
- busy  out  1  scheduler not idle.
- frame_done  out  1  one-cycle pulse, coincident with the cycle vs_o falls.
- frcnt  out  CNT_WIDTH  frames completed since start.
- underflow  out  1  sticky: s_valid was low while s_ready was high.

Behaviour:
- Reset (rst_n=0 at posedge): next cycle all outputs are 0 and state is IDLE. Applies mid-frame too; no frame_done is generated for the aborted frame.
- FSM states: IDLE, VBLANK, ACTIVE, HBLANK.
- IDLE:
  - start=1 latches all cfg_* into shadow registers, clears frcnt, underflow and stop_pend, then goes to VBLANK.
  - cfg_* changes while busy have no effect.
  - Zero geometry values are clamped to 1 at latch time (cfg_frames excluded).
- VBLANK: runs shadow vblank cycles with vs/hs/de all 0, then goes to ACTIVE with line counter = 0.
- ACTIVE: runs shadow pix_count cycles, then goes to HBLANK.
  - s_ready = 1 combinationally whenever state is ACTIVE and only then.
- HBLANK: runs shadow hblank cycles.
  - On the last cycle: if line counter = line_count-1, the frame ends; otherwise increment the line counter and go to ACTIVE.
- Frame end:
  - frcnt increments.
  - If stop_pend, or (cfg_frames ≠ 0 and new frcnt = cfg_frames), go to IDLE; else go to VBLANK.
- Output timing (all outputs registered, 1-cycle latency from state):
  - de_o = previous state was ACTIVE.
  - hs_o = previous state was HBLANK.
  - vs_o = previous state was ACTIVE or HBLANK.
  - di_o = s_di when s_valid, else 0.
  - frame_done asserts in the cycle vs_o goes 1→0.
  - busy = state ≠ IDLE, registered with the same latency as the video outputs.
- Underflow: s_ready & !s_valid keeps de_o asserted, drives di_o = 0 and sets underflow. Timing is never stalled.
- Command rules:
  - stop while busy sets stop_pend, so the current frame completes.
  - stop in IDLE is ignored.
  - start while busy is ignored.
  - start and stop in the same IDLE cycle: start wins and stop_pend is set, so exactly one frame is emitted.
- Counter width: frcnt wraps modulo 2^CNT_WIDTH in continuous mode.
- Frame length: vblank + line_count × (pix_count + hblank) cycles.

Decomposition:
- Package vid_sched_pkg holds:
  - the state enum type;
  - a cfg_t struct (pix, line, hblank, vblank, frames);
  - localparam MIN_BLANK = 1.
- One natural sub-module, vid_sched_cnt: a loadable down-counter with a terminal-count flag. It is instantiated for the cycle counter and for the line counter.

Test Plan:
- Geometry 4×3, hblank=2, vblank=3, frames=1, s_valid always 1:
  - 12 de cycles, 3 hs pulses of 2 cycles each.
  - vs high for 18 cycles.
  - One frame_done, frcnt=1.
  - busy falls after 3 + 18 cycles.
- frames=0, stop asserted mid-frame 2: frame 2 completes fully, then IDLE with frcnt=2. No partial frame.
- s_valid dropped for 1 cycle during ACTIVE: de_o stays 1, di_o=0 on that cycle, underflow=1 until the next start.
- Geometry all zeros: behaves as 1×1, hblank=1, vblank=1; one de pulse per frame.
- Reset pulled low mid-ACTIVE: next cycle all outputs 0 and no frame_done; a subsequent start runs normally.
- start and stop in the same cycle with frames=0: exactly one frame, frcnt=1; a second start while busy is ignored.

Source files
------------

// File: rtl/vid_sched_pkg.sv
// Shared types for the parallel-video frame scheduler: FSM states, the latched
// geometry record and the clamp applied to zero-valued geometry.
package vid_sched_pkg;

  localparam int unsigned MIN_BLANK = 1;

  typedef enum logic [1:0] {
    IDLE,
    VBLANK,
    ACTIVE,
    HBLANK
  } state_t;

  // Fields are held at 32 bits so any CNT_WIDTH up to 32 fits; unused upper bits stay zero.
  typedef struct packed {
    logic [31:0] pix;
    logic [31:0] line;
    logic [31:0] hblank;
    logic [31:0] vblank;
    logic [31:0] frames;
  } cfg_t;

  function automatic logic [31:0] clamp_min(input logic [31:0] v);
    return (v < MIN_BLANK) ? MIN_BLANK : v;
  endfunction

endpackage

// File: rtl/vid_sched_cnt.sv
// Loadable down-counter with a terminal-count flag (count == 0); holds at zero.
module vid_sched_cnt #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/vid_frame_sched.sv
// Frame scheduler: sequences VBLANK / ACTIVE / HBLANK timing, pulls pixels from a
// ready/valid source and emits registered de/hs/vs video with frame accounting.
module vid_frame_sched
  import vid_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_WIDTH-1:0]  cfg_pix_count,
  input  logic [CNT_WIDTH-1:0]  cfg_line_count,
  input  logic [CNT_WIDTH-1:0]  cfg_hblank,
  input  logic [CNT_WIDTH-1:0]  cfg_vblank,
  input  logic [CNT_WIDTH-1:0]  cfg_frames,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] s_di,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] di_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frcnt,
  output logic                  underflow
);

  state_t state, state_nx;
  cfg_t   sh, lat, eff;

  logic                 cyc_tc, line_tc;
  logic                 cyc_load, cyc_en;
  logic [CNT_WIDTH-1:0] cyc_load_val;
  logic                 line_load, line_en;
  logic [CNT_WIDTH-1:0] line_load_val;
  logic                 frame_end, last_frame, stop_pend;
  logic [CNT_WIDTH-1:0] frcnt_inc;

  logic                  de_d, hs_d, vs_d, busy_d, fd_d;
  logic [DATA_WIDTH-1:0] di_d;

  always_comb begin
    lat.pix    = clamp_min(32'(cfg_pix_count));
    lat.line   = clamp_min(32'(cfg_line_count));
    lat.hblank = clamp_min(32'(cfg_hblank));
    lat.vblank = clamp_min(32'(cfg_vblank));
    lat.frames = 32'(cfg_frames);
  end

  // The first VBLANK load happens in the same cycle the shadow is written, so it
  // reads the clamped live config; every later load uses the shadow copy.
  assign eff = (state == IDLE) ? lat : sh;

  assign frcnt_inc  = frcnt + CNT_WIDTH'(1);
  assign frame_end  = (state == HBLANK) && cyc_tc && line_tc;
  assign last_frame = stop_pend || stop ||
                      ((sh.frames != '0) && (frcnt_inc == CNT_WIDTH'(sh.frames)));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)  state_nx = VBLANK;
      VBLANK:  if (cyc_tc) state_nx = ACTIVE;
      ACTIVE:  if (cyc_tc) state_nx = HBLANK;
      HBLANK:
        if (cyc_tc) begin
          if (!line_tc)        state_nx = ACTIVE;
          else if (last_frame) state_nx = IDLE;
          else                 state_nx = VBLANK;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cyc_load     = (state == IDLE) ? start : cyc_tc;
    cyc_en       = (state != IDLE);
    cyc_load_val = '0;
    unique case (state_nx)
      VBLANK:  cyc_load_val = CNT_WIDTH'(eff.vblank - 32'd1);
      ACTIVE:  cyc_load_val = CNT_WIDTH'(eff.pix - 32'd1);
      HBLANK:  cyc_load_val = CNT_WIDTH'(eff.hblank - 32'd1);
      default: cyc_load_val = '0;
    endcase
    // Line counter counts remaining lines; terminal count marks the last line.
    line_load     = (state == VBLANK) && cyc_tc;
    line_load_val = CNT_WIDTH'(sh.line - 32'd1);
    line_en       = (state == HBLANK) && cyc_tc && !line_tc;
  end

  vid_sched_cnt #(.WIDTH(CNT_WIDTH)) u_cyc_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cyc_load),
    .load_val (cyc_load_val),
    .en       (cyc_en),
    .tc       (cyc_tc)
  );

  vid_sched_cnt #(.WIDTH(CNT_WIDTH)) u_line_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (line_load),
    .load_val (line_load_val),
    .en       (line_en),
    .tc       (line_tc)
  );

  assign s_ready = (state == ACTIVE);

  always_comb begin
    de_d   = (state == ACTIVE);
    hs_d   = (state == HBLANK);
    vs_d   = (state == ACTIVE) || (state == HBLANK);
    busy_d = (state != IDLE);
    fd_d   = vs_o && !vs_d;
    di_d   = (s_ready && s_valid) ? s_di : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh         <= '0;
      frcnt      <= '0;
      stop_pend  <= 1'b0;
      underflow  <= 1'b0;
      de_o       <= 1'b0;
      hs_o       <= 1'b0;
      vs_o       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      di_o       <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        sh        <= lat;
        frcnt     <= '0;
        underflow <= 1'b0;
        stop_pend <= stop;
      end else begin
        if ((state != IDLE) && stop) stop_pend <= 1'b1;
        if (frame_end)               frcnt     <= frcnt_inc;
        if (s_ready && !s_valid)     underflow <= 1'b1;
      end
      de_o       <= de_d;
      hs_o       <= hs_d;
      vs_o       <= vs_d;
      busy       <= busy_d;
      frame_done <= fd_d;
      di_o       <= di_d;
    end
  end

endmodule

// File: tb/tb_vid_frame_sched.sv
// Directed, table-driven bench for vid_frame_sched with hand-computed timing counts.
module tb_vid_frame_sched;

  localparam int DW  = 8;
  localparam int CW  = 12;
  localparam logic [DW-1:0] PIX = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] cfg_pix_count, cfg_line_count, cfg_hblank, cfg_vblank, cfg_frames;
  logic          start, stop;
  logic [DW-1:0] s_di;
  logic          s_valid, s_ready;
  logic [DW-1:0] di_o;
  logic          de_o, hs_o, vs_o, busy, frame_done, underflow;
  logic [CW-1:0] frcnt;

  vid_frame_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_pix_count  (cfg_pix_count),
    .cfg_line_count (cfg_line_count),
    .cfg_hblank     (cfg_hblank),
    .cfg_vblank     (cfg_vblank),
    .cfg_frames     (cfg_frames),
    .start          (start),
    .stop           (stop),
    .s_di           (s_di),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .di_o           (di_o),
    .de_o           (de_o),
    .hs_o           (hs_o),
    .vs_o           (vs_o),
    .busy           (busy),
    .frame_done     (frame_done),
    .frcnt          (frcnt),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix, line, hb, vb, fr;
    int de, hs, vs, fd, frc, bsy;
  } vec_t;

  vec_t tbl [5];
  int checks = 0;
  int errors = 0;
  int n_de, n_hs, n_vs, n_fd, n_busy, n_dibad, n_rstbad, timed_out;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int pix, line, hb, vb, fr);
    cfg_pix_count  = CW'(pix);
    cfg_line_count = CW'(line);
    cfg_hblank     = CW'(hb);
    cfg_vblank     = CW'(vb);
    cfg_frames     = CW'(fr);
  endtask

  // Issues start (optionally with stop), then scrambles cfg and counts video
  // activity until busy falls. Indices select the loop cycle for extra events.
  task automatic run_seq(input int stop_at, input int restart_at, input int drop_at,
                         input int rst_at, input bit with_stop);
    bit seen, done, prev_valid;
    n_de = 0; n_hs = 0; n_vs = 0; n_fd = 0; n_busy = 0;
    n_dibad = 0; n_rstbad = 0; timed_out = 0;
    seen = 0; done = 0; prev_valid = 1'b1;
    @(negedge clk);
    start = 1'b1; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    for (int i = 1; i <= 600 && !done; i++) begin
      @(negedge clk);
      if (de_o) begin
        n_de++;
        if (di_o != (prev_valid ? PIX : '0)) n_dibad++;
      end
      if (hs_o)       n_hs++;
      if (vs_o)       n_vs++;
      if (frame_done) n_fd++;
      if (busy) begin
        n_busy++;
        seen = 1;
      end
      if (i == rst_at + 1) begin
        if (de_o || hs_o || vs_o || busy || frame_done || underflow ||
            (frcnt != '0) || (di_o != '0)) n_rstbad++;
      end
      if (seen && !busy) done = 1;
      rst_n      = (i != rst_at);
      stop       = (i == stop_at);
      start      = (i == restart_at);
      s_valid    = (i != drop_at);
      prev_valid = s_valid;
    end
    if (!done) timed_out = 1;
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b1;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    set_cfg(v.pix, v.line, v.hb, v.vb, v.fr);
    run_seq(-1, -1, -1, -1, 1'b0);
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_de"},      n_de,      v.de);
    chk({tag, "_hs"},      n_hs,      v.hs);
    chk({tag, "_vs"},      n_vs,      v.vs);
    chk({tag, "_fdone"},   n_fd,      v.fd);
    chk({tag, "_frcnt"},   int'(frcnt), v.frc);
    chk({tag, "_busy"},    n_busy,    v.bsy);
    chk({tag, "_di"},      n_dibad,   0);
    chk({tag, "_uflow"},   int'(underflow), 0);
  endtask

  initial begin
    // pix line hb vb fr | de hs vs fd frcnt busy
    tbl[0] = '{4, 3, 2, 3, 1, 12, 6, 18, 1, 1, 21};
    tbl[1] = '{0, 0, 0, 0, 1,  1, 1,  2, 1, 1,  3};
    tbl[2] = '{2, 2, 1, 2, 3, 12, 6, 18, 3, 3, 24};
    tbl[3] = '{0, 0, 0, 0, 2,  2, 2,  4, 2, 2,  6};
    tbl[4] = '{3, 1, 4, 1, 1,  3, 4,  7, 1, 1,  8};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    s_di = PIX; s_valid = 1'b1;
    set_cfg(4, 3, 2, 3, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outs", int'({de_o, hs_o, vs_o, busy, frame_done, underflow, s_ready}), 0);
    chk("reset_frcnt", int'(frcnt), 0);
    chk("reset_di", int'(di_o), 0);

    // stop in IDLE must be ignored: next start still runs to cfg_frames
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;

    for (int k = 0; k < 5; k++) check_vec($sformatf("vec%0d", k), tbl[k]);

    // Continuous mode, stop raised in the middle of frame 2
    set_cfg(2, 2, 1, 2, 0);
    run_seq(12, -1, -1, -1, 1'b0);
    chk("stop_timeout", timed_out, 0);
    chk("stop_frcnt", int'(frcnt), 2);
    chk("stop_fdone", n_fd, 2);
    chk("stop_de", n_de, 8);
    chk("stop_busy", n_busy, 16);

    // start+stop together gives exactly one frame; a start while busy is ignored
    set_cfg(2, 2, 1, 2, 0);
    run_seq(-1, 3, -1, -1, 1'b1);
    chk("ss_timeout", timed_out, 0);
    chk("ss_frcnt", int'(frcnt), 1);
    chk("ss_fdone", n_fd, 1);
    chk("ss_de", n_de, 4);
    chk("ss_busy", n_busy, 8);

    // One-cycle valid drop during ACTIVE
    set_cfg(4, 3, 2, 3, 1);
    run_seq(-1, -1, 4, -1, 1'b0);
    chk("uf_timeout", timed_out, 0);
    chk("uf_de", n_de, 12);
    chk("uf_di", n_dibad, 0);
    chk("uf_vs", n_vs, 18);
    repeat (4) @(negedge clk);
    chk("uf_sticky", int'(underflow), 1);
    check_vec("uf_clear", tbl[0]);

    // Reset pulled mid-ACTIVE, then a normal run
    set_cfg(4, 3, 2, 3, 1);
    run_seq(-1, -1, -1, 4, 1'b0);
    chk("rst_timeout", timed_out, 0);
    chk("rst_outs", n_rstbad, 0);
    chk("rst_fdone", n_fd, 0);
    chk("rst_frcnt", int'(frcnt), 0);
    check_vec("post_rst", tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
